// File: rtl/mod_counter_lap.sv
// Modulo-N up/down counter stage with load, wrap/saturate mode, cascade carry and lap capture.
// Stages chain carry_out -> enable to form seconds/minutes/hours of the timer datapath.
module mod_counter_lap #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_VAL   = 99,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             lap,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] lap_count,
    output logic             lap_valid,
    output logic             carry_out,
    output logic             ovf
);

    localparam longint unsigned RANGE_LIMIT = (64'd1 << WIDTH) - 64'd1;
    localparam bit CFG_OK = (MAX_VAL >= 32'd1) && (64'(MAX_VAL) <= RANGE_LIMIT) &&
                            (RESET_VAL <= MAX_VAL);

    generate
        if (!CFG_OK) begin : g_bad_cfg
            $error("mod_counter_lap: illegal WIDTH/MAX_VAL/RESET_VAL combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(32'd1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] lap_count_r;
    logic             lap_valid_r;
    logic             ovf_r;

    logic [WIDTH-1:0] count_nxt_s;
    logic             ovf_nxt_s;
    logic             at_max_s;
    logic             at_zero_s;

    assign at_max_s  = (count_r == MAX_W);
    assign at_zero_s = (count_r == ZERO_W);

    // Next count and overflow flag, priority clear > load > enable; reset is applied in the register.
    always_comb begin
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        if (clear) begin
            count_nxt_s = ZERO_W;
            ovf_nxt_s   = 1'b0;
        end else if (load) begin
            // Out-of-range load values clamp so count never leaves 0..MAX_VAL.
            if (load_val > MAX_W) begin
                count_nxt_s = MAX_W;
            end else begin
                count_nxt_s = load_val;
            end
        end else if (enable) begin
            if (up_dn) begin
                if (at_max_s) begin
                    count_nxt_s = SATURATE ? MAX_W : ZERO_W;
                    ovf_nxt_s   = 1'b1;
                end else begin
                    count_nxt_s = count_r + ONE_W;
                end
            end else begin
                if (at_zero_s) begin
                    count_nxt_s = SATURATE ? ZERO_W : MAX_W;
                    ovf_nxt_s   = 1'b1;
                end else begin
                    count_nxt_s = count_r - ONE_W;
                end
            end
        end else begin
            count_nxt_s = count_r;
            ovf_nxt_s   = ovf_r;
        end
    end

    // Count and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= RESET_W;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Lap capture samples the pre-update count; clear without lap invalidates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_count_r <= ZERO_W;
            lap_valid_r <= 1'b0;
        end else if (lap) begin
            lap_count_r <= count_r;
            lap_valid_r <= 1'b1;
        end else if (clear) begin
            lap_count_r <= lap_count_r;
            lap_valid_r <= 1'b0;
        end else begin
            lap_count_r <= lap_count_r;
            lap_valid_r <= lap_valid_r;
        end
    end

    // Zero-latency terminal-count pulse so the downstream stage steps on the same edge.
    assign carry_out = enable & ~clear & ~load & ~rst &
                       ((up_dn & at_max_s) | (~up_dn & at_zero_s));

    assign count     = count_r;
    assign lap_count = lap_count_r;
    assign lap_valid = lap_valid_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_mod_counter_lap.sv
// Directed testbench for mod_counter_lap: wrap, saturate, load/clamp, lap, cascade and mid-run reset.
module tb_mod_counter_lap;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance a (seconds) and b (minutes): MAX_VAL=59, wrap, cascaded.
    logic       a_clear, a_load, a_en, a_up, a_lap;
    logic [5:0] a_load_val, a_count, a_lap_count;
    logic       a_lap_valid, a_carry, a_ovf;
    logic       b_clear, b_load, b_up, b_lap;
    logic [5:0] b_load_val, b_count, b_lap_count;
    logic       b_lap_valid, b_carry, b_ovf;
    // Instance s: MAX_VAL=59, saturate.
    logic       s_clear, s_load, s_en, s_up, s_lap;
    logic [5:0] s_load_val, s_count, s_lap_count;
    logic       s_lap_valid, s_carry, s_ovf;
    // Instance l: WIDTH=8, MAX_VAL=99, RESET_VAL=7, wrap.
    logic       l_clear, l_load, l_en, l_up, l_lap;
    logic [7:0] l_load_val, l_count, l_lap_count;
    logic       l_lap_valid, l_carry, l_ovf;

    mod_counter_lap #(.WIDTH(6), .MAX_VAL(59), .SATURATE(1'b0), .RESET_VAL(0)) u_a (
        .clk(clk), .rst(rst), .clear(a_clear), .load(a_load), .load_val(a_load_val),
        .enable(a_en), .up_dn(a_up), .lap(a_lap), .count(a_count), .lap_count(a_lap_count),
        .lap_valid(a_lap_valid), .carry_out(a_carry), .ovf(a_ovf));

    mod_counter_lap #(.WIDTH(6), .MAX_VAL(59), .SATURATE(1'b0), .RESET_VAL(0)) u_b (
        .clk(clk), .rst(rst), .clear(b_clear), .load(b_load), .load_val(b_load_val),
        .enable(a_carry), .up_dn(b_up), .lap(b_lap), .count(b_count), .lap_count(b_lap_count),
        .lap_valid(b_lap_valid), .carry_out(b_carry), .ovf(b_ovf));

    mod_counter_lap #(.WIDTH(6), .MAX_VAL(59), .SATURATE(1'b1), .RESET_VAL(0)) u_s (
        .clk(clk), .rst(rst), .clear(s_clear), .load(s_load), .load_val(s_load_val),
        .enable(s_en), .up_dn(s_up), .lap(s_lap), .count(s_count), .lap_count(s_lap_count),
        .lap_valid(s_lap_valid), .carry_out(s_carry), .ovf(s_ovf));

    mod_counter_lap #(.WIDTH(8), .MAX_VAL(99), .SATURATE(1'b0), .RESET_VAL(7)) u_l (
        .clk(clk), .rst(rst), .clear(l_clear), .load(l_load), .load_val(l_load_val),
        .enable(l_en), .up_dn(l_up), .lap(l_lap), .count(l_count), .lap_count(l_lap_count),
        .lap_valid(l_lap_valid), .carry_out(l_carry), .ovf(l_ovf));

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        a_clear = 1'b0; a_load = 1'b0; a_en = 1'b0; a_up = 1'b1; a_lap = 1'b0; a_load_val = 6'd0;
        b_clear = 1'b0; b_load = 1'b0; b_up = 1'b1; b_lap = 1'b0; b_load_val = 6'd0;
        s_clear = 1'b0; s_load = 1'b0; s_en = 1'b0; s_up = 1'b1; s_lap = 1'b0; s_load_val = 6'd0;
        l_clear = 1'b0; l_load = 1'b0; l_en = 1'b0; l_up = 1'b1; l_lap = 1'b0; l_load_val = 8'd0;
        step();
        step();
        chk("rst_a_count", a_count, 0);
        chk("rst_l_count", l_count, 7);
        chk("rst_l_ovf", l_ovf, 0);
        chk("rst_l_lap_valid", l_lap_valid, 0);
        chk("rst_l_lap_count", l_lap_count, 0);
        chk("rst_b_count", b_count, 0);
        rst = 1'b0;

        // Up count 0..59 and wrap; carry only at 59.
        a_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            chk("a_up_count", a_count, i);
            chk("a_up_carry", a_carry, (i == 59) ? 1 : 0);
            step();
        end
        chk("a_wrap_count", a_count, 0);
        chk("a_wrap_ovf", a_ovf, 1);
        chk("b_same_edge", b_count, 1);

        // Cascade to 3600 ticks total.
        for (int k = 60; k < 3600; k++) begin
            if ((k % 60) == 59) begin
                chk("casc_b_count", b_count, (k / 60) % 60);
                chk("casc_b_carry", b_carry, (((k / 60) % 60) == 59) ? 1 : 0);
            end
            step();
        end
        a_en = 1'b0;
        chk("casc_a_end", a_count, 0);
        chk("casc_b_end", b_count, 0);
        chk("casc_b_ovf", b_ovf, 1);

        // Down wrap.
        a_clear = 1'b1;
        step();
        a_clear = 1'b0;
        chk("a_clr_count", a_count, 0);
        chk("a_clr_ovf", a_ovf, 0);
        a_up = 1'b0; a_en = 1'b1;
        #1;
        chk("a_dn_carry", a_carry, 1);
        step();
        a_en = 1'b0;
        chk("a_dn_count", a_count, 59);
        chk("a_dn_ovf", a_ovf, 1);

        // Saturate at both limits.
        s_en = 1'b1; s_up = 1'b0;
        #1;
        chk("s_dn_carry", s_carry, 1);
        step();
        s_en = 1'b0;
        chk("s_dn_count", s_count, 0);
        chk("s_dn_ovf", s_ovf, 1);
        s_load = 1'b1; s_load_val = 6'd59;
        step();
        s_load = 1'b0;
        chk("s_load", s_count, 59);
        s_en = 1'b1; s_up = 1'b1;
        #1;
        chk("s_up_carry", s_carry, 1);
        step();
        chk("s_up_count", s_count, 59);
        s_clear = 1'b1;
        #1;
        chk("s_clr_carry", s_carry, 0);
        step();
        s_clear = 1'b0; s_en = 1'b0;
        chk("s_clr_count", s_count, 0);
        chk("s_clr_ovf", s_ovf, 0);

        // Load and clamp.
        l_load = 1'b1; l_load_val = 8'd42;
        step();
        chk("l_load42", l_count, 42);
        l_load_val = 8'd200;
        step();
        l_load = 1'b0;
        chk("l_clamp", l_count, 99);
        chk("l_clamp_ovf", l_ovf, 0);
        l_en = 1'b1; l_up = 1'b1;
        #1;
        chk("l_max_carry", l_carry, 1);
        step();
        l_en = 1'b0;
        chk("l_wrap_count", l_count, 0);
        chk("l_wrap_ovf", l_ovf, 1);
        l_load = 1'b1; l_load_val = 8'd99;
        step();
        chk("l_load99", l_count, 99);
        chk("l_load_keeps_ovf", l_ovf, 1);
        l_load_val = 8'd10; l_en = 1'b1;
        #1;
        chk("l_ld_en_carry", l_carry, 0);
        step();
        chk("l_ld_en_count", l_count, 10);
        l_clear = 1'b1;
        step();
        l_clear = 1'b0; l_load = 1'b0; l_en = 1'b0;
        chk("l_clr_ld_en", l_count, 0);
        chk("l_clr_ovf", l_ovf, 0);

        // Lap capture.
        l_load = 1'b1; l_load_val = 8'd17;
        step();
        l_load = 1'b0;
        chk("l_load17", l_count, 17);
        l_lap = 1'b1; l_en = 1'b1;
        step();
        l_lap = 1'b0; l_en = 1'b0;
        chk("lap_count17", l_lap_count, 17);
        chk("lap_count_18", l_count, 18);
        chk("lap_valid1", l_lap_valid, 1);
        l_lap = 1'b1; l_clear = 1'b1;
        step();
        l_lap = 1'b0; l_clear = 1'b0;
        chk("lap_clr_lap", l_lap_count, 18);
        chk("lap_clr_count", l_count, 0);
        chk("lap_clr_valid", l_lap_valid, 1);
        l_clear = 1'b1;
        step();
        l_clear = 1'b0;
        chk("clr_valid0", l_lap_valid, 0);
        chk("clr_stale_lap", l_lap_count, 18);

        // Reset mid-count at 33 with ovf and lap_valid set.
        l_load = 1'b1; l_load_val = 8'd99;
        step();
        l_load = 1'b0; l_en = 1'b1;
        step();
        l_en = 1'b0; l_load = 1'b1; l_load_val = 8'd33;
        step();
        l_load = 1'b0; l_lap = 1'b1;
        step();
        l_lap = 1'b0;
        chk("pre_rst_count", l_count, 33);
        chk("pre_rst_ovf", l_ovf, 1);
        chk("pre_rst_valid", l_lap_valid, 1);
        chk("pre_rst_lap", l_lap_count, 33);
        rst = 1'b1; l_en = 1'b1; l_load = 1'b1; l_load_val = 8'd50;
        s_en = 1'b1; s_up = 1'b0;
        #1;
        chk("rst_l_carry", l_carry, 0);
        chk("rst_s_carry", s_carry, 0);
        step();
        rst = 1'b0; l_en = 1'b0; l_load = 1'b0; s_en = 1'b0;
        chk("mid_rst_count", l_count, 7);
        chk("mid_rst_ovf", l_ovf, 0);
        chk("mid_rst_valid", l_lap_valid, 0);
        chk("mid_rst_lap", l_lap_count, 0);
        chk("mid_rst_s_count", s_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
